// File: rtl/sixteen_bit_adder_pkg.sv
// Shared sizing constants for the 16-bit carry-lookahead adder.
package sixteen_bit_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned GROUP_W       = 4;
  localparam int unsigned NUM_GROUPS    = WIDTH_DEFAULT / GROUP_W;

  typedef logic [GROUP_W-1:0] nibble_t;

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate.
module cla4_group
  import sixteen_bit_adder_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    G,
  output logic    P
);

  nibble_t g;
  nibble_t p;
  nibble_t c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Fully expanded internal carries, no ripple between bit positions
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    s = p ^ c;
    G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    P = &p;
  end

endmodule

// File: rtl/sixteen_bit_adder.sv
// Registered 16-bit two-level carry-lookahead adder with async active-low reset.
module sixteen_bit_adder
  import sixteen_bit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS-1:0] grp_c;
  logic [WIDTH-1:0]      sum_next;
  logic                  carry_out;

  for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_grp
    cla4_group u_grp (
      .a  (a[i*GROUP_W +: GROUP_W]),
      .b  (b[i*GROUP_W +: GROUP_W]),
      .ci (grp_c[i]),
      .s  (sum_next[i*GROUP_W +: GROUP_W]),
      .G  (grp_g[i]),
      .P  (grp_p[i])
    );
  end

  // Second-level lookahead: every group carry is expanded straight from cin
  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    carry_out = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else begin
      sum <= sum_next;
      co  <= carry_out;
    end
  end

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Scoreboard bench for sixteen_bit_adder against a 17-bit reference sum.
module tb_sixteen_bit_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        co;

  int unsigned total;
  int unsigned bad;
  logic [16:0] sb[$];

  sixteen_bit_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .co    (co)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got co,sum=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Drive one operand set just after an edge, push its result, compare after the next edge
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] exp;
    a = x; b = y; cin = c;
    sb.push_back(ref_add(x, y, c));
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check(tag, {co, sum}, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] vec;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 1'b1;

    #2 rst_n = 1'b0;
    #1 check("reset_immediate", {co, sum}, 17'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", {co, sum}, 17'h0);

    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step("basic_2345", 16'h1234, 16'h1111, 1'b0);
    check("basic_2345_const", {co, sum}, 17'h0_2345);

    // Inputs moving between edges must not disturb the registered outputs
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    #5 check("hold_between_edges", {co, sum}, 17'h0_2345);

    step("full_propagate", 16'hFFFF, 16'h0000, 1'b1);
    check("full_propagate_const", {co, sum}, 17'h1_0000);
    step("all_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1);
    check("all_ones_cin_const", {co, sum}, 17'h1_FFFF);
    step("msb_carry", 16'h8000, 16'h8000, 1'b0);
    check("msb_carry_const", {co, sum}, 17'h1_0000);
    step("msb_no_carry", 16'h7FFF, 16'h0001, 1'b0);
    check("msb_no_carry_const", {co, sum}, 17'h0_8000);
    step("zero", 16'h0000, 16'h0000, 1'b0);

    // Async reset while co=1, with a pending operand set that must be discarded
    step("pre_reset_carry", 16'hFFFF, 16'h0001, 1'b0);
    a = 16'h0001; b = 16'h0001; cin = 1'b0;
    sb.push_back(ref_add(a, b, cin));
    #4 rst_n = 1'b0;
    #1 check("async_reset_drop", {co, sum}, 17'h0);
    sb.delete();
    @(posedge clk); #1;
    check("reset_discards_pending", {co, sum}, 17'h0);
    #3 rst_n = 1'b1;
    step("first_after_release", 16'h0005, 16'h0006, 1'b0);
    check("first_after_release_const", {co, sum}, 17'h0_000B);

    vec = {16'hFFF0, 16'hFF80, 1'b0};
    for (int i = 0; i < 2000; i++) begin
      step("increment", vec[32:17], vec[16:1], vec[0]);
      vec = vec + 33'd1;
    end

    for (int i = 0; i < 10000; i++) begin
      step("random", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_adder.md
SIXTEEN_BIT_ADDER -- requirements
Module: sixteen_bit_adder

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of 4 and is fixed at 16 for this release.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: a  input  16  unsigned addend A.
REQ-006 Port: b  input  16  unsigned addend B.
REQ-007 Port: cin  input  1  carry-in, weight 1.
REQ-008 Port: sum  output  16  registered low 16 bits of a+b+cin.
REQ-009 Port: co  output  1  registered carry-out, bit 16 of a+b+cin.

Function
REQ-010 On each rising clk edge with rst_n high, {co,sum} SHALL load the 17-bit result a+b+cin computed from the a, b and cin values present at that edge.
REQ-011 Latency SHALL be exactly one clock; there is no handshake; a new operand set is accepted every cycle.
REQ-012 Between edges, sum and co SHALL hold their values regardless of input changes.
REQ-013 Arithmetic SHALL be unsigned modulo 2^16 on sum; co SHALL be 1 iff a+b+cin >= 65536.
REQ-014 Wrap-around: a=16'hFFFF, b=0, cin=1 SHALL give sum=0, co=1; a=b=16'hFFFF, cin=1 SHALL give sum=16'hFFFF, co=1.
REQ-015 The combinational adder SHALL be carry-lookahead: four 4-bit lookahead groups with group generate/propagate combined by a second-level lookahead unit; ripple-only carry chains across groups are not permitted.
REQ-016 Group carries SHALL be c4=G0|P0&cin, c8=G1|P1&c4, c12=G2|P2&c8, co=G3|P3&c12, with all terms expanded in the second-level unit.
REQ-017 Outputs SHALL never be X after reset for any known-valued inputs.

Reset
REQ-018 While rst_n is low, sum SHALL be 16'h0000 and co SHALL be 0, asserted immediately without waiting for clk.
REQ-019 Reset asserted mid-operation SHALL discard the pending result; the first result after release SHALL come from the first rising edge with rst_n high.
REQ-020 Deassertion SHALL require no synchronisation inside the block; the system reset controller guarantees synchronous release.

Structure
REQ-021 A shared package sixteen_bit_adder_pkg SHALL hold WIDTH_DEFAULT=16, GROUP_W=4 and NUM_GROUPS=WIDTH/GROUP_W.
REQ-022 One sub-module cla4_group SHALL implement a 4-bit group: inputs a[3:0], b[3:0], ci; outputs s[3:0], group generate G, group propagate P; instantiated four times.
REQ-023 The second-level lookahead and the output register SHALL reside in sixteen_bit_adder; no other sub-modules.

Verification
REQ-024 rst_n=0 with a=16'h1234, b=16'h1111, cin=1 -> sum=0, co=0 immediately and held while reset is low.
REQ-025 Release reset, a=16'h1234, b=16'h1111, cin=0 -> after one edge sum=16'h2345, co=0.
REQ-026 a=16'hFFFF, b=16'h0000, cin=1 -> next edge sum=16'h0000, co=1 (full carry propagation across all groups).
REQ-027 a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, co=1; then a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, co=0.
REQ-028 Free-running stimulus {a,b,cin} incremented by 1 every 20 ns, plus 10000 random vectors -> every registered result equals a+b+cin of the previous edge, checked against a 17-bit reference model.
REQ-029 Assert rst_n low asynchronously between edges while co=1 -> sum and co drop to 0 before the next clk edge.
